// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl
// Power-on / reload sequencer for the CPU external load ports. A go pulse
// streams N_INSTR instruction words and then N_DATA data words out of a
// 1-cycle-latency boot ROM into the CPU write ports. It then holds the CPU in
// reset for RST_CYCLES cycles and raises start.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   go             start / restart a load; honoured only in IDLE and RUN
//   rom_rd         ROM read strobe
//   rom_addr       ROM word address
//   rom_rdata      ROM data, valid the cycle after rom_rd
//   ext_instr*     instruction word / byte address / write enable to the CPU
//   ext_data*      data word / byte address / write enable to the CPU
//   cpu_rst_n      CPU reset, active low
//   start          CPU run enable
//   busy           high while a load or the CPU reset hold is in progress
module boot_load_ctrl #(
  parameter int N_INSTR    = 6,
  parameter int N_DATA     = 10,
  parameter int RST_CYCLES = 2,
  parameter int ROM_AW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              rom_rd,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_rdata,
  output logic [31:0]       ext_instr,
  output logic [31:0]       ext_instr_addr,
  output logic              ext_instr_en,
  output logic [31:0]       ext_data,
  output logic [31:0]       ext_data_addr,
  output logic              ext_data_en,
  output logic              cpu_rst_n,
  output logic              start,
  output logic              busy
);

  // One counter serves every timed phase, so it must reach the longest one.
  localparam int MAXC = (N_INSTR > N_DATA)
                        ? ((N_INSTR > RST_CYCLES) ? N_INSTR : RST_CYCLES)
                        : ((N_DATA > RST_CYCLES) ? N_DATA : RST_CYCLES);
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] LAST_I = CW'(N_INSTR - 1);
  // Data phase is unreachable when N_DATA is 0; keep the constant legal.
  localparam logic [CW-1:0] LAST_D = CW'((N_DATA > 0) ? (N_DATA - 1) : 0);
  localparam logic [CW-1:0] LAST_R = CW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_GAP_I,
    S_LOAD_D,
    S_GAP_D,
    S_HOLD_RST,
    S_RUN
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic [CW-1:0]   r_idx;
  logic            r_en_i;
  logic            r_en_d;
  logic            w_en_i_next;
  logic            w_en_d_next;
  logic [31:0]     w_idx_byte_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_en_i  <= 1'b0;
      r_en_d  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // Index of the word read this cycle; its ROM data arrives next cycle.
      r_idx   <= r_cnt;
      r_en_i  <= w_en_i_next;
      r_en_d  <= w_en_d_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_en_i_next  = 1'b0;
    w_en_d_next  = 1'b0;
    rom_rd       = 1'b0;
    rom_addr     = '0;
    cpu_rst_n    = 1'b1;
    start        = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (go) begin
          w_state_next = S_LOAD_I;
          w_cnt_next   = '0;
        end
      end
      S_LOAD_I: begin
        rom_rd      = 1'b1;
        rom_addr    = ROM_AW'(r_cnt);
        w_en_i_next = 1'b1;
        if (r_cnt == LAST_I) begin
          w_state_next = S_GAP_I;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_GAP_I: begin
        // Last instruction write lands here; no read is issued.
        w_cnt_next   = '0;
        w_state_next = (N_DATA > 0) ? S_LOAD_D : S_HOLD_RST;
      end
      S_LOAD_D: begin
        rom_rd      = 1'b1;
        rom_addr    = ROM_AW'(N_INSTR) + ROM_AW'(r_cnt);
        w_en_d_next = 1'b1;
        if (r_cnt == LAST_D) begin
          w_state_next = S_GAP_D;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_GAP_D: begin
        w_cnt_next   = '0;
        w_state_next = S_HOLD_RST;
      end
      S_HOLD_RST: begin
        cpu_rst_n = 1'b0;
        if (r_cnt == LAST_R) begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        busy  = 1'b0;
        start = 1'b1;
        if (go) begin
          w_state_next = S_LOAD_I;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign w_idx_byte_addr = 32'(r_idx) << 2;

  // Write ports are forced to zero whenever their enable is low.
  assign ext_instr_en   = r_en_i;
  assign ext_instr      = r_en_i ? rom_rdata : 32'd0;
  assign ext_instr_addr = r_en_i ? w_idx_byte_addr : 32'd0;
  assign ext_data_en    = r_en_d;
  assign ext_data       = r_en_d ? rom_rdata : 32'd0;
  assign ext_data_addr  = r_en_d ? w_idx_byte_addr : 32'd0;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Testbench for boot_load_ctrl: a default instance (6/10/2) and a no-data
// instance (3/0/2) share clock, reset and go. A per-instance reference model
// tracks the cycle number since the accepted go and derives every expected
// output from the phase lengths.
module tb_boot_load_ctrl;

  logic clk;
  logic rst;
  logic go;

  logic [31:0] rom [256];

  // Default instance signals
  logic        a_rom_rd;
  logic [7:0]  a_rom_addr;
  logic [31:0] a_rom_rdata;
  logic [31:0] a_ext_instr, a_ext_instr_addr, a_ext_data, a_ext_data_addr;
  logic        a_ext_instr_en, a_ext_data_en, a_cpu_rst_n, a_start, a_busy;

  // No-data instance signals
  logic        b_rom_rd;
  logic [7:0]  b_rom_addr;
  logic [31:0] b_rom_rdata;
  logic [31:0] b_ext_instr, b_ext_instr_addr, b_ext_data, b_ext_data_addr;
  logic        b_ext_instr_en, b_ext_data_en, b_cpu_rst_n, b_start, b_busy;

  boot_load_ctrl #(.N_INSTR(6), .N_DATA(10), .RST_CYCLES(2), .ROM_AW(8)) u_dut_a (
    .clk(clk), .rst(rst), .go(go),
    .rom_rd(a_rom_rd), .rom_addr(a_rom_addr), .rom_rdata(a_rom_rdata),
    .ext_instr(a_ext_instr), .ext_instr_addr(a_ext_instr_addr), .ext_instr_en(a_ext_instr_en),
    .ext_data(a_ext_data), .ext_data_addr(a_ext_data_addr), .ext_data_en(a_ext_data_en),
    .cpu_rst_n(a_cpu_rst_n), .start(a_start), .busy(a_busy)
  );

  boot_load_ctrl #(.N_INSTR(3), .N_DATA(0), .RST_CYCLES(2), .ROM_AW(8)) u_dut_b (
    .clk(clk), .rst(rst), .go(go),
    .rom_rd(b_rom_rd), .rom_addr(b_rom_addr), .rom_rdata(b_rom_rdata),
    .ext_instr(b_ext_instr), .ext_instr_addr(b_ext_instr_addr), .ext_instr_en(b_ext_instr_en),
    .ext_data(b_ext_data), .ext_data_addr(b_ext_data_addr), .ext_data_en(b_ext_data_en),
    .cpu_rst_n(b_cpu_rst_n), .start(b_start), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Boot ROM with one cycle of read latency, one port per instance.
  always @(posedge clk) begin
    if (a_rom_rd) a_rom_rdata <= rom[a_rom_addr];
    if (b_rom_rd) b_rom_rdata <= rom[b_rom_addr];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // t = 0: idle (never started since reset). t >= 1: cycle number after the
  // accepted go; it saturates at the first RUN cycle.
  typedef struct packed {
    logic        rd;
    logic [7:0]  ra;
    logic        ie;
    logic [31:0] ia;
    logic [31:0] id;
    logic        de;
    logic [31:0] da;
    logic [31:0] dd;
    logic        rn;
    logic        st;
    logic        bz;
  } exp_t;

  function automatic int hold_start(input int ni, input int nd);
    return (nd > 0) ? (ni + nd + 3) : (ni + 2);
  endfunction

  function automatic int next_t(input int t, input int ni, input int nd, input int rc,
                                input logic r, input logic g);
    int rs;
    rs = hold_start(ni, nd) + rc;
    if (r) return 0;
    if (t == 0) return g ? 1 : 0;
    if (t >= rs) return g ? 1 : rs;
    return t + 1;
  endfunction

  function automatic exp_t expect_at(input int t, input int ni, input int nd, input int rc);
    exp_t e;
    int hs;
    e = '0;
    e.rn = 1'b1;
    if (t == 0) return e;
    hs = hold_start(ni, nd);
    if (t <= ni) begin
      e.rd = 1'b1;
      e.ra = 8'(t - 1);
    end else if (nd > 0 && t >= ni + 2 && t <= ni + 1 + nd) begin
      e.rd = 1'b1;
      e.ra = 8'(t - 2);
    end
    if (t >= 2 && t <= ni + 1) begin
      e.ie = 1'b1;
      e.ia = 32'(4 * (t - 2));
      e.id = rom[t - 2];
    end
    if (nd > 0 && t >= ni + 3 && t <= ni + nd + 2) begin
      e.de = 1'b1;
      e.da = 32'(4 * (t - ni - 3));
      e.dd = rom[t - 3];
    end
    e.rn = !(t >= hs && t < hs + rc);
    e.st = (t >= hs + rc);
    e.bz = (t < hs + rc);
    return e;
  endfunction

  int t_a = 0;
  int t_b = 0;

  always @(posedge clk) begin
    t_a <= next_t(t_a, 6, 10, 2, rst, go);
    t_b <= next_t(t_b, 3, 0, 2, rst, go);
    cyc <= cyc + 1;
  end

  int a_iw = 0;
  int a_dw = 0;

  always @(negedge clk) begin
    exp_t ea;
    exp_t eb;
    if (chk_en) begin
      ea = expect_at(t_a, 6, 10, 2);
      eb = expect_at(t_b, 3, 0, 2);
      $display("cyc=%0d tA=%0d tB=%0d A:ie=%0b de=%0b rn=%0b st=%0b B:ie=%0b rn=%0b st=%0b",
               cyc, t_a, t_b, a_ext_instr_en, a_ext_data_en, a_cpu_rst_n, a_start,
               b_ext_instr_en, b_cpu_rst_n, b_start);
      check_val("a_rom_rd", 32'(a_rom_rd), 32'(ea.rd));
      if (ea.rd) check_val("a_rom_addr", 32'(a_rom_addr), 32'(ea.ra));
      check_val("a_ie", 32'(a_ext_instr_en), 32'(ea.ie));
      check_val("a_iaddr", a_ext_instr_addr, ea.ia);
      check_val("a_idata", a_ext_instr, ea.id);
      check_val("a_de", 32'(a_ext_data_en), 32'(ea.de));
      check_val("a_daddr", a_ext_data_addr, ea.da);
      check_val("a_ddata", a_ext_data, ea.dd);
      check_val("a_cpu_rst_n", 32'(a_cpu_rst_n), 32'(ea.rn));
      check_val("a_start", 32'(a_start), 32'(ea.st));
      check_val("a_busy", 32'(a_busy), 32'(ea.bz));
      check_val("a_excl", 32'(a_ext_instr_en & a_ext_data_en), 32'd0);

      check_val("b_rom_rd", 32'(b_rom_rd), 32'(eb.rd));
      if (eb.rd) check_val("b_rom_addr", 32'(b_rom_addr), 32'(eb.ra));
      check_val("b_ie", 32'(b_ext_instr_en), 32'(eb.ie));
      check_val("b_iaddr", b_ext_instr_addr, eb.ia);
      check_val("b_idata", b_ext_instr, eb.id);
      check_val("b_de", 32'(b_ext_data_en), 32'd0);
      check_val("b_cpu_rst_n", 32'(b_cpu_rst_n), 32'(eb.rn));
      check_val("b_start", 32'(b_start), 32'(eb.st));
      check_val("b_busy", 32'(b_busy), 32'(eb.bz));
      if (a_ext_instr_en) a_iw++;
      if (a_ext_data_en)  a_dw++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    go  = 1'b0;
    for (int k = 0; k < 256; k++) rom[k] = 32'hA000_0000 + 32'(k);
    step(2);
    chk_en = 1'b1;

    // Default load, then reload from RUN.
    rst = 1'b0;
    step(2);
    go = 1'b1;
    step(1);
    go = 1'b0;
    step(30);
    go = 1'b1;
    step(1);
    go = 1'b0;

    // Reset in cycle 4 of the reload, then a fresh load from new contents.
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int k = 0; k < 256; k++) rom[k] = $urandom;
    step(2);
    go = 1'b1;
    step(1);
    go = 1'b0;
    step(30);

    // go held high through the whole load: exactly one set of writes.
    a_iw = 0;
    a_dw = 0;
    go = 1'b1;
    step(21);
    go = 1'b0;
    step(6);
    check_val("a_instr_writes", 32'(a_iw), 32'd6);
    check_val("a_data_writes", 32'(a_dw), 32'd10);

    // Random go / reset traffic.
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      go  = ($urandom_range(0, 9) == 0);
      step(1);
    end
    rst = 1'b0;
    go  = 1'b0;
    step(30);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
